// File: rtl/kbd_text_pkg.sv
// Shared constants and enumerations for the keyboard text buffer.
package kbd_text_pkg;

  localparam logic [5:0] CH_BLANK = 6'd0;
  localparam logic [5:0] CH_A     = 6'd1;
  localparam logic [5:0] CH_0     = 6'd27;
  localparam logic [5:0] CH_SPACE = 6'd37;

  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_WRITE, ST_CLEAR} state_e;
  typedef enum logic [1:0] {CLS_CHAR, CLS_BKSP, CLS_ENTER, CLS_NONE} cls_e;

endpackage

// File: rtl/kbd_scan2char.sv
// Combinational PS/2 set-2 scancode to {class, character code} lookup.
module kbd_scan2char
  import kbd_text_pkg::*;
(
  input  logic [7:0] scancode,
  output logic [1:0] cls,
  output logic [5:0] code
);

  always_comb begin
    cls  = CLS_CHAR;
    code = CH_BLANK;
    case (scancode)
      8'h1C: code = CH_A + 6'd0;   8'h32: code = CH_A + 6'd1;
      8'h21: code = CH_A + 6'd2;   8'h23: code = CH_A + 6'd3;
      8'h24: code = CH_A + 6'd4;   8'h2B: code = CH_A + 6'd5;
      8'h34: code = CH_A + 6'd6;   8'h33: code = CH_A + 6'd7;
      8'h43: code = CH_A + 6'd8;   8'h3B: code = CH_A + 6'd9;
      8'h42: code = CH_A + 6'd10;  8'h4B: code = CH_A + 6'd11;
      8'h3A: code = CH_A + 6'd12;  8'h31: code = CH_A + 6'd13;
      8'h44: code = CH_A + 6'd14;  8'h4D: code = CH_A + 6'd15;
      8'h15: code = CH_A + 6'd16;  8'h2D: code = CH_A + 6'd17;
      8'h1B: code = CH_A + 6'd18;  8'h2C: code = CH_A + 6'd19;
      8'h3C: code = CH_A + 6'd20;  8'h2A: code = CH_A + 6'd21;
      8'h1D: code = CH_A + 6'd22;  8'h22: code = CH_A + 6'd23;
      8'h35: code = CH_A + 6'd24;  8'h1A: code = CH_A + 6'd25;
      8'h45: code = CH_0 + 6'd0;   8'h16: code = CH_0 + 6'd1;
      8'h1E: code = CH_0 + 6'd2;   8'h26: code = CH_0 + 6'd3;
      8'h25: code = CH_0 + 6'd4;   8'h2E: code = CH_0 + 6'd5;
      8'h36: code = CH_0 + 6'd6;   8'h3D: code = CH_0 + 6'd7;
      8'h3E: code = CH_0 + 6'd8;   8'h46: code = CH_0 + 6'd9;
      SC_SPACE: code = CH_SPACE;
      SC_BKSP:  cls  = CLS_BKSP;
      SC_ENTER: cls  = CLS_ENTER;
      default:  cls  = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/kbd_text_buffer.sv
// One-line text buffer fed by released-key scancodes, with a registered
// read port for the VGA text renderer.
module kbd_text_buffer
  import kbd_text_pkg::*;
#(
  parameter int COLS = 32,
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    scancode,
  input  logic          scan_valid,
  input  logic [CW-1:0] rd_addr,
  output logic [5:0]    rd_data,
  output logic [CW:0]   cursor,
  output logic          full,
  output logic          busy,
  output logic          overrun
);

  localparam logic [CW:0]   COLS_W   = (CW+1)'(COLS);
  localparam logic [CW:0]   ONE_W    = (CW+1)'(1);
  localparam logic [CW-1:0] ONE_I    = CW'(1);
  localparam logic [CW-1:0] LAST_IDX = CW'(COLS - 1);

  state_e        state_q, state_d;
  logic [7:0]    sc_q, sc_d;
  cls_e          cls_q, cls_d;
  logic [5:0]    code_q, code_d;
  logic [CW:0]   cursor_q, cursor_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          overrun_q, overrun_d;
  logic [5:0]    rd_data_q, rd_data_d;
  logic [5:0]    buf_q [COLS];
  logic [5:0]    buf_d [COLS];
  logic [1:0]    lk_cls;
  logic [5:0]    lk_code;

  kbd_scan2char u_scan2char (
    .scancode (sc_q),
    .cls      (lk_cls),
    .code     (lk_code)
  );

  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    cls_d     = cls_q;
    code_d    = code_q;
    cursor_d  = cursor_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    // Read uses the pre-update array, so a same-edge write returns the old value.
    rd_data_d = buf_q[rd_addr];
    overrun_d = overrun_q | (scan_valid && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (scan_valid) begin
          sc_d    = scancode;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        cls_d   = cls_e'(lk_cls);
        code_d  = lk_code;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        case (cls_q)
          CLS_CHAR: begin
            if (cursor_q < COLS_W) begin
              buf_d[cursor_q[CW-1:0]] = code_q;
              cursor_d                = cursor_q + ONE_W;
            end
          end
          CLS_BKSP: begin
            if (cursor_q != '0) begin
              cursor_d                = cursor_q - ONE_W;
              buf_d[cursor_d[CW-1:0]] = CH_BLANK;
            end
          end
          CLS_ENTER: begin
            idx_d   = '0;
            state_d = ST_CLEAR;
          end
          default: ;
        endcase
      end
      ST_CLEAR: begin
        buf_d[idx_q] = CH_BLANK;
        idx_d        = idx_q + ONE_I;
        if (idx_q == LAST_IDX) begin
          cursor_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sc_q      <= '0;
      cls_q     <= CLS_NONE;
      code_q    <= '0;
      cursor_q  <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      rd_data_q <= '0;
      buf_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      cls_q     <= cls_d;
      code_q    <= code_d;
      cursor_q  <= cursor_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      rd_data_q <= rd_data_d;
      buf_q     <= buf_d;
    end
  end

  assign rd_data = rd_data_q;
  assign cursor  = cursor_q;
  assign full    = (cursor_q == COLS_W);
  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_kbd_text_buffer.sv
// Randomized scoreboard bench for kbd_text_buffer against a line-editor model.
module tb_kbd_text_buffer;

  localparam int COLS = 32;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    scancode = 8'h00;
  logic          scan_valid = 1'b0;
  logic [CW-1:0] rd_addr = '0;
  logic [5:0]    rd_data;
  logic [CW:0]   cursor;
  logic          full, busy, overrun;

  always #5 clk = ~clk;

  kbd_text_buffer #(.COLS(COLS), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .scancode   (scancode),
    .scan_valid (scan_valid),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cursor     (cursor),
    .full       (full),
    .busy       (busy),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the line as an array of codes plus a cursor.
  int m_buf [COLS];
  int m_cur = 0;
  int m_ovr = 0;

  typedef struct {int addr; int data;} rd_exp_t;
  rd_exp_t sb[$];
  logic rd_req = 1'b0;
  logic pend = 1'b0;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                               8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                              8'h3D, 8'h3E, 8'h46};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int char_of(input logic [7:0] sc);
    for (int i = 0; i < 26; i++) if (letters[i] == sc) return i + 1;
    for (int i = 0; i < 10; i++) if (digits[i] == sc) return 27 + i;
    if (sc == 8'h29) return 37;
    return -1;
  endfunction

  task automatic model_apply(input logic [7:0] sc, output int bcyc);
    int c;
    c = char_of(sc);
    bcyc = 2;
    if (c >= 0) begin
      if (m_cur < COLS) begin
        m_buf[m_cur] = c;
        m_cur++;
      end
    end else if (sc == 8'h66) begin
      if (m_cur > 0) begin
        m_cur--;
        m_buf[m_cur] = 0;
      end
    end else if (sc == 8'h5A) begin
      for (int i = 0; i < COLS; i++) m_buf[i] = 0;
      m_cur = 0;
      bcyc = 2 + COLS;
    end
  endtask

  always @(posedge clk) pend <= rd_req;

  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk($sformatf("rd_data[%0d]", e.addr), int'(rd_data), e.data);
      end
    end
  end

  task automatic read_one(input int a);
    @(negedge clk);
    rd_addr = CW'(a);
    rd_req  = 1'b1;
    sb.push_back('{addr: a, data: m_buf[a]});
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < COLS; a++) begin
      @(negedge clk);
      rd_addr = CW'(a);
      rd_req  = 1'b1;
      sb.push_back('{addr: a, data: m_buf[a]});
    end
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  // rbw: read the write column on the WRITE edge; inj: strobe while busy.
  task automatic send_ev(input logic [7:0] sc, input bit rbw = 1'b0, input int inj = 0);
    int exp_b, cnt, widx, old;
    @(negedge clk);
    scancode   = sc;
    scan_valid = 1'b1;
    widx = (m_cur < COLS) ? m_cur : 0;
    old  = m_buf[widx];
    model_apply(sc, exp_b);
    if (inj > 0) m_ovr = 1;
    @(negedge clk);
    scan_valid = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      scan_valid = (cnt == inj);
      if (cnt == inj) scancode = 8'h1C;
      if (rbw && cnt == 2) begin
        rd_addr = CW'(widx);
        rd_req  = 1'b1;
        sb.push_back('{addr: widx, data: old});
      end else rd_req = 1'b0;
      @(negedge clk);
    end
    scan_valid = 1'b0;
    rd_req     = 1'b0;
    chk($sformatf("busy_cycles sc=%h", sc), cnt, exp_b);
    chk("cursor", int'(cursor), m_cur);
    chk("full", int'(full), int'(m_cur == COLS));
    chk("overrun", int'(overrun), m_ovr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, idx;
    logic [7:0] sc;
    for (int i = 0; i < COLS; i++) m_buf[i] = 0;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    send_ev(8'h1C); send_ev(8'h32); send_ev(8'h21);
    read_all();

    send_ev(8'h5A);
    send_ev(8'h45); send_ev(8'h29); send_ev(8'h16);
    read_all();
    send_ev(8'h66);
    read_one(2);
    repeat (5) send_ev(8'h66);

    send_ev(8'h5A);
    for (int i = 0; i < COLS; i++) send_ev(8'h1A, (i % 8) == 0);
    send_ev(8'h1C);
    read_all();
    send_ev(8'h66);
    read_all();

    send_ev(8'h5A);
    send_ev(8'h24); send_ev(8'h3E); send_ev(8'h4D);
    send_ev(8'h5A, 1'b0, 5);
    read_all();

    send_ev(8'h2C); send_ev(8'h76);
    read_all();

    send_ev(8'h1C); send_ev(8'h1C);
    @(negedge clk);
    scancode   = 8'h5A;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < COLS; i++) m_buf[i] = 0;
    m_cur = 0;
    m_ovr = 0;
    chk("arst_cursor", int'(cursor), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_overrun", int'(overrun), 0);
    chk("arst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    reset = 1'b1;
    read_all();
    send_ev(8'h1C);
    read_one(0);
    read_one(1);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        idx = $urandom_range(0, 36);
        sc = (idx < 26) ? letters[idx] : (idx < 36) ? digits[idx-26] : 8'h29;
      end else if (r < 80) sc = 8'h66;
      else if (r < 84) sc = 8'h5A;
      else begin
        sc = 8'($urandom_range(0, 255));
        if (char_of(sc) >= 0 || sc == 8'h66 || sc == 8'h5A) sc = 8'h76;
      end
      send_ev(sc, (r % 7) == 0 && char_of(sc) >= 0);
      read_one($urandom_range(0, COLS-1));
      if (n % 50 == 49) read_all();
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
